// File: rtl/rc5_16_pkg.sv
// rc5_16_pkg: constants, FSM state type and 8-bit rotate helpers
// shared by the 16-bit RC5 encryptor and decryptor.
package rc5_16_pkg;

    localparam logic [7:0] RC5_S0 = 8'h20;
    localparam logic [7:0] RC5_S1 = 8'h10;
    localparam logic [7:0] RC5_S2 = 8'h0F;
    localparam logic [7:0] RC5_S3 = 8'hFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNDO_B = 3'd1,
        UNDO_A = 3'd2,
        UNSEED = 3'd3,
        OUT    = 3'd4
    } state_e;

    // Rotating a doubled copy keeps n=0 an identity with no
    // shift-by-8 edge case.
    function automatic logic [7:0] rotl8(
        input logic [7:0] x,
        input logic [2:0] n
    );
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] rotr8(
        input logic [7:0] x,
        input logic [2:0] n
    );
        logic [15:0] t;
        t = {x, x} >> n;
        return t[7:0];
    endfunction

endpackage

// File: rtl/rc5_rotr8.sv
// rc5_rotr8: combinational 8-bit rotate-right by 0..7.
// Ports: data_i (8b), amt_i (3b), data_o (8b).
module rc5_rotr8
    import rc5_16_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic [2:0] amt_i,
    output logic [7:0] data_o
);

    assign data_o = rotr8(data_i, amt_i);

endmodule

// File: rtl/rc5_dec_16bit.sv
// rc5_dec_16bit: one-round 16-bit RC5 decryptor, valid/ready on both sides.
// Ports: clock, reset (async low), c/c_valid/c_ready in, p/p_valid/p_ready out.
// Optional macro RC5_DEC_COUNT_EN adds dec_count[7:0], a saturating count
// of completed output handshakes.
module rc5_dec_16bit
    import rc5_16_pkg::*;
#(
    parameter logic [7:0] S0 = RC5_S0,
    parameter logic [7:0] S1 = RC5_S1,
    parameter logic [7:0] S2 = RC5_S2,
    parameter logic [7:0] S3 = RC5_S3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] c,
    input  logic        c_valid,
    output logic        c_ready,
    output logic [15:0] p,
    output logic        p_valid,
`ifdef RC5_DEC_COUNT_EN
    input  logic        p_ready,
    output logic [7:0]  dec_count
`else
    input  logic        p_ready
`endif
);

    state_e      state_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] p_q;
    logic        p_valid_q;

    logic [7:0]  b_rot;
    logic [7:0]  a_rot;
    logic [7:0]  b_d;
    logic [7:0]  a_d;

    rc5_rotr8 u_rotr_b (
        .data_i (b_q - S3),
        .amt_i  (a_q[2:0]),
        .data_o (b_rot)
    );

    // B has already been restored when this path is used.
    rc5_rotr8 u_rotr_a (
        .data_i (a_q - S2),
        .amt_i  (b_q[2:0]),
        .data_o (a_rot)
    );

    assign b_d = b_rot ^ a_q;
    assign a_d = a_rot ^ b_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            p_q       <= 16'h0000;
            p_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (c_valid) begin
                        a_q     <= c[15:8];
                        b_q     <= c[7:0];
                        state_q <= UNDO_B;
                    end
                end
                UNDO_B: begin
                    b_q     <= b_d;
                    state_q <= UNDO_A;
                end
                UNDO_A: begin
                    a_q     <= a_d;
                    state_q <= UNSEED;
                end
                UNSEED: begin
                    p_q       <= {a_q - S0, b_q - S1};
                    p_valid_q <= 1'b1;
                    state_q   <= OUT;
                end
                OUT: begin
                    if (p_ready) begin
                        p_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    p_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign c_ready = (state_q == IDLE);
    assign p       = p_q;
    assign p_valid = p_valid_q;

`ifdef RC5_DEC_COUNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'h00;
        end else if (p_valid_q && p_ready && cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'h01;
        end
    end

    assign dec_count = cnt_q;
`endif

endmodule

// File: tb/tb_rc5_dec_16bit.sv
// tb_rc5_dec_16bit: scoreboard bench for rc5_dec_16bit; a reference
// encryptor produces ciphertexts and the expected plaintexts.
module tb_rc5_dec_16bit;

    logic        clock;
    logic        reset;
    logic [15:0] c;
    logic        c_valid;
    logic        c_ready;
    logic [15:0] p;
    logic        p_valid;
    logic        p_ready;
`ifdef RC5_DEC_COUNT_EN
    logic [7:0]  dec_count;
`endif

    rc5_dec_16bit dut (
        .clock     (clock),
        .reset     (reset),
        .c         (c),
        .c_valid   (c_valid),
        .c_ready   (c_ready),
        .p         (p),
        .p_valid   (p_valid),
`ifdef RC5_DEC_COUNT_EN
        .p_ready   (p_ready),
        .dec_count (dec_count)
`else
        .p_ready   (p_ready)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int n_sent = 0;
    int n_out = 0;
    logic [15:0] exp_q[$];
    int          acc_q[$];
    logic        pv_prev = 1'b0;
    logic        rand_mode = 1'b0;
    logic        pr_force = 1'b1;

    always @(posedge clock) cyc <= cyc + 1;

    // single driver of p_ready, updated just after each rising edge
    initial begin
        p_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            p_ready = rand_mode ? ($urandom_range(0, 2) != 0) : pr_force;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] rol(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < n % 8; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // forward RC5 round: seed with S0/S1, then mix A and B
    function automatic logic [15:0] enc(input logic [15:0] pt);
        logic [7:0] a, b;
        a = pt[15:8] + 8'h20;
        b = pt[7:0] + 8'h10;
        a = rol(a ^ b, int'(b)) + 8'h0F;
        b = rol(b ^ a, int'(a)) + 8'hFF;
        return {a, b};
    endfunction

    // monitor: latency on each rising p_valid, data on each handshake
    always @(negedge clock) begin
        if (reset) begin
            if (p_valid && !pv_prev) begin
                if (acc_q.size() == 0) check("latency_nostamp", 1, 0);
                else check("latency", cyc - acc_q.pop_front(), 3);
            end
            if (p_valid && p_ready) begin
                n_out++;
                if (exp_q.size() == 0) check("unexpected_p", int'(p), -1);
                else check("p", int'(p), int'(exp_q.pop_front()));
            end
        end
        pv_prev <= p_valid;
    end

    task automatic send(input logic [15:0] cw, input logic [15:0] ep);
        int n;
        @(negedge clock);
        c = cw;
        c_valid = 1'b1;
        n = 0;
        while (!c_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!c_ready) begin
            check("accept_timeout", 0, 1);
            c_valid = 1'b0;
        end else begin
            exp_q.push_back(ep);
            acc_q.push_back(cyc + 1);
            n_sent++;
            @(posedge clock);
            #1;
            c_valid = 1'b0;
        end
    endtask

    task automatic wait_pvalid();
        int n;
        n = 0;
        while (!p_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!p_valid) check("pvalid_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] pt;
        reset = 1'b0;
        c = 16'h0000;
        c_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_p", int'(p), 0);
        check("rst_pvalid", int'(p_valid), 0);
        check("rst_cready", int'(c_ready), 1);
        reset = 1'b1;
        @(negedge clock);
        check("cready_idle", int'(c_ready), 1);

        // zero plaintext, p_ready high: one-cycle p_valid pulse
        send(16'h3F96, 16'h0000);
        wait_pvalid();
        @(negedge clock);
        check("pvalid_width", int'(p_valid), 0);
        drain();

        // rotate amounts 6 and 4
        send(16'h768B, 16'h1234);
        drain();

        // consumer stall
        pr_force = 1'b0;
        repeat (2) @(negedge clock);
        send(16'h768B, 16'h1234);
        wait_pvalid();
        for (int i = 0; i < 10; i++) begin
            check("stall_pvalid", int'(p_valid), 1);
            check("stall_p", int'(p), 16'h1234);
            check("stall_cready", int'(c_ready), 0);
            @(negedge clock);
        end
        pr_force = 1'b1;
        @(posedge clock);
        #2;
        @(posedge clock);
        #1;
        check("release_cready", int'(c_ready), 1);
        check("release_pvalid", int'(p_valid), 0);
        drain();

        // reset while UNDO_A is in progress
        send(16'h768B, 16'h1234);
        @(posedge clock);
        #2;
        reset = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("midrst_p", int'(p), 0);
        check("midrst_pvalid", int'(p_valid), 0);
        check("midrst_cready", int'(c_ready), 1);
        @(negedge clock);
        reset = 1'b1;
        n_sent = 0;
        n_out = 0;
        send(16'h3F96, 16'h0000);
        drain();

        // random traffic with gaps and backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 500; i++) begin
            pt = 16'($urandom());
            send(enc(pt), pt);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        drain();
        repeat (3) @(negedge clock);
        check("out_count", n_out, n_sent);
        rand_mode = 1'b0;

`ifdef RC5_DEC_COUNT_EN
        repeat (2) @(negedge clock);
        for (int i = 0; i < 260; i++) begin
            pt = 16'($urandom());
            send(enc(pt), pt);
        end
        drain();
        repeat (2) @(negedge clock);
        check("count_sat", int'(dec_count), 8'hFF);
        reset = 1'b0;
        #1;
        check("count_rst", int'(dec_count), 0);
        @(negedge clock);
        reset = 1'b1;
`endif

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
